// File: rtl/wb_pic16.sv
// Wishbone-slave interrupt controller: synchronises up to 16 sources, latches edge events
// into PENDING, masks them with ENABLE and drives a registered irq_o.
module wb_pic16 #(
    parameter int unsigned NUM_IRQ     = 5,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] EDGE_RESET  = 16'hFFFF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [15:0]        wb_dat_i,
    output logic [15:0]        wb_dat_o,
    input  logic [1:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic               wb_ack_o,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               irq_o
);

    localparam logic [15:0] IMPL_MASK = 16'((32'd1 << NUM_IRQ) - 32'd1);

    // Internal vectors are a full 16 bits wide; bits at or above NUM_IRQ are held at 0.
    logic [SYNC_STAGES-1:0][15:0] r_sync;
    logic [15:0] r_prev;
    logic [15:0] r_pending;
    logic [15:0] r_enable;
    logic [15:0] r_edge;
    logic [15:0] r_dat;
    logic        r_ack;
    logic        r_irq;

    logic [15:0] w_irq;
    logic [15:0] w_s;
    logic [15:0] w_rise;
    logic [15:0] w_lane;
    logic [15:0] w_w1c;
    logic [15:0] w_pend_nxt;
    logic [15:0] w_act;
    logic [3:0]  w_act_idx;
    logic [15:0] w_rdata;
    logic [1:0]  w_reg;
    logic        w_acc;
    logic        w_wr;
    logic        w_unused_adr;

    assign w_irq        = 16'(irq_i);
    assign w_s          = r_sync[SYNC_STAGES-1];
    assign w_rise       = w_s & ~r_prev;
    assign w_reg        = wb_adr_i[2:1];
    assign w_acc        = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr         = w_acc & wb_we_i;
    assign w_lane       = {{8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_w1c        = (w_wr && (w_reg == 2'd0)) ? (wb_dat_i & w_lane) : 16'h0000;
    assign w_unused_adr = ^{wb_adr_i[31:3], wb_adr_i[0]};

    // A rising edge outranks a W1C in the same cycle; level-mode bits simply track s.
    assign w_pend_nxt = IMPL_MASK & ((r_edge & (w_rise | (r_pending & ~w_w1c)))
                                     | (~r_edge & w_s));

    always_comb begin
        w_act     = r_pending & r_enable;
        w_act_idx = 4'd0;
        for (int n = 15; n >= 0; n--) begin
            if (w_act[n]) begin
                w_act_idx = 4'(n);
            end
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        case (w_reg)
            2'd0:    w_rdata = r_pending;
            2'd1:    w_rdata = r_enable;
            2'd2:    w_rdata = r_edge;
            default: w_rdata = (|w_act) ? {1'b1, 11'd0, w_act_idx} : 16'h0000;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync    <= '0;
            r_prev    <= 16'h0000;
            r_pending <= 16'h0000;
            r_enable  <= 16'h0000;
            r_edge    <= EDGE_RESET & IMPL_MASK;
            r_dat     <= 16'h0000;
            r_ack     <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], w_irq};
            r_prev    <= w_s;
            r_pending <= w_pend_nxt;
            if (w_wr && (w_reg == 2'd1)) begin
                r_enable <= IMPL_MASK & ((r_enable & ~w_lane) | (wb_dat_i & w_lane));
            end
            if (w_wr && (w_reg == 2'd2)) begin
                r_edge <= IMPL_MASK & ((r_edge & ~w_lane) | (wb_dat_i & w_lane));
            end
            r_irq <= |w_act;
            r_ack <= w_acc;
            r_dat <= w_acc ? w_rdata : 16'h0000;
        end
    end

    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign irq_o    = r_irq;

endmodule

// File: tb/tb_wb_pic16.sv
// Bench for wb_pic16: directed scenarios plus randomised bus/interrupt traffic, all
// checked every cycle against a delay-line reference model.
module tb_wb_pic16;

    localparam int unsigned NI  = 5;
    localparam int unsigned SS  = 2;
    localparam logic [15:0] ER  = 16'hFFFF;
    localparam logic [15:0] MSK = 16'h001F;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic [31:0]   adr   = 32'h0;
    logic [15:0]   dat_i = 16'h0;
    logic [15:0]   dat_o;
    logic [1:0]    sel   = 2'b00;
    logic          we    = 1'b0;
    logic          cyc   = 1'b0;
    logic          stb   = 1'b0;
    logic          ack;
    logic [NI-1:0] irq   = '0;
    logic          irq_o;

    always #5 clk = ~clk;

    wb_pic16 #(
        .NUM_IRQ     (NI),
        .SYNC_STAGES (SS),
        .EDGE_RESET  (ER)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_ack_o (ack),
        .irq_i    (irq),
        .irq_o    (irq_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: hist[k] is the irq_i vector sampled k+1 edges ago.
    logic [15:0] hist[$];
    logic [15:0] m_pend, m_en, m_edge, m_dat;
    logic        m_ack, m_irq;

    task automatic model_reset();
        hist = {};
        for (int k = 0; k <= SS; k++) hist.push_back(16'h0000);
        m_pend = 16'h0000;
        m_en   = 16'h0000;
        m_edge = ER & MSK;
        m_dat  = 16'h0000;
        m_ack  = 1'b0;
        m_irq  = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] s, pv, lane, rdv, act, w1c;
        logic        acc;
        int          idx;
        if (rst) begin
            model_reset();
            return;
        end
        s    = hist[SS-1];
        pv   = hist[SS];
        acc  = cyc && stb && !m_ack;
        act  = m_pend & m_en;
        idx  = 0;
        for (int n = 15; n >= 0; n--) if (act[n]) idx = n;
        case (adr[2:1])
            2'd0:    rdv = m_pend;
            2'd1:    rdv = m_en;
            2'd2:    rdv = m_edge;
            default: rdv = (act != 16'h0) ? (16'h8000 | 16'(idx)) : 16'h0000;
        endcase
        lane  = {{8{sel[1]}}, {8{sel[0]}}};
        w1c   = (acc && we && adr[2:1] == 2'd0) ? (dat_i & lane) : 16'h0000;
        m_irq = (act != 16'h0);
        for (int n = 0; n < NI; n++) begin
            if (m_edge[n]) begin
                if (s[n] && !pv[n]) m_pend[n] = 1'b1;
                else if (w1c[n])    m_pend[n] = 1'b0;
            end else begin
                m_pend[n] = s[n];
            end
        end
        if (acc && we && adr[2:1] == 2'd1) m_en   = ((m_en & ~lane) | (dat_i & lane)) & MSK;
        if (acc && we && adr[2:1] == 2'd2) m_edge = ((m_edge & ~lane) | (dat_i & lane)) & MSK;
        m_ack = acc;
        m_dat = acc ? rdv : 16'h0000;
        hist.push_front(16'(irq));
        void'(hist.pop_back());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("irq_o", {31'd0, irq_o}, {31'd0, m_irq});
                check("ack_o", {31'd0, ack}, {31'd0, m_ack});
                check("dat_o", {16'd0, dat_o}, {16'd0, m_dat});
            end
        end
    end

    task automatic bus(input logic w, input logic [1:0] a, input logic [15:0] d,
                       input logic [1:0] s, output logic [15:0] rd);
        bit got = 1'b0;
        rd = 16'h0000;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat_i = d;
        adr = 32'hF000_0010 | {29'd0, a, 1'b0};
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                got = 1'b1;
                rd  = dat_o;
            end
        end
        check("ack_timeout", {31'd0, got}, 32'd1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        logic [15:0] v;
        bus(1'b1, a, d, 2'b11, v);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] v;
        bus(1'b0, a, 16'h0, 2'b11, v);
        check(tag, {16'd0, v}, {16'd0, exp});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset values
        rd_chk("rst_pending", 2'd0, 16'h0000);
        rd_chk("rst_enable",  2'd1, 16'h0000);
        rd_chk("rst_edge",    2'd2, 16'h001F);
        rd_chk("rst_active",  2'd3, 16'h0000);

        // Edge latch and clear
        wr(2'd1, 16'h0001);
        @(negedge clk); irq[0] = 1'b1;
        @(posedge clk); @(posedge clk); #1 irq[0] = 1'b0;
        @(posedge clk); #1 check("edge_irq_e3", {31'd0, irq_o}, 32'd0);
        @(posedge clk); #1 check("edge_irq_e4", {31'd0, irq_o}, 32'd1);
        rd_chk("edge_pending", 2'd0, 16'h0001);
        rd_chk("edge_active",  2'd3, 16'h8000);
        wr(2'd0, 16'h0001);
        @(posedge clk); #1 check("w1c_irq_low", {31'd0, irq_o}, 32'd0);
        rd_chk("w1c_pending", 2'd0, 16'h0000);

        // Priority and masking
        wr(2'd2, 16'h001F);
        wr(2'd1, 16'h0018);
        @(negedge clk); irq = 5'b11010;
        repeat (2) @(negedge clk);
        irq = '0;
        repeat (4) @(negedge clk);
        rd_chk("prio_pending", 2'd0, 16'h001A);
        rd_chk("prio_active",  2'd3, 16'h8003);
        wr(2'd0, 16'h0008);
        rd_chk("prio_active2", 2'd3, 16'h8004);
        wr(2'd0, 16'h001F);

        // Level mode
        wr(2'd2, 16'h0000);
        wr(2'd1, 16'h0004);
        @(negedge clk); irq[2] = 1'b1;
        repeat (5) @(negedge clk);
        check("lvl_irq_high", {31'd0, irq_o}, 32'd1);
        wr(2'd0, 16'h0004);
        rd_chk("lvl_w1c_ignored", 2'd0, 16'h0004);
        @(negedge clk); irq[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("lvl_drop_e3", {31'd0, irq_o}, 32'd1);
        @(posedge clk); #1 check("lvl_drop_e4", {31'd0, irq_o}, 32'd0);

        // Set-wins collision on line 0
        wr(2'd2, 16'h001F);
        wr(2'd1, 16'h0001);
        @(negedge clk); irq[0] = 1'b1;
        repeat (2) @(negedge clk);
        irq[0] = 1'b0;
        repeat (4) @(negedge clk);
        irq[0] = 1'b1;
        @(negedge clk);
        wr(2'd0, 16'h0001);
        rd_chk("set_wins", 2'd0, 16'h0001);
        irq[0] = 1'b0;
        wr(2'd0, 16'h001F);

        // Handshake with cyc/stb held for 6 cycles
        cnt = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hF000_0010;
        repeat (6) begin
            @(posedge clk);
            #1 if (ack) cnt++;
        end
        @(negedge clk); cyc = 1'b0; stb = 1'b0;
        check("ack_pulses", cnt, 32'd3);

        // Byte lanes
        begin
            logic [15:0] v;
            wr(2'd1, 16'h0000);
            bus(1'b1, 2'd1, 16'hFFFF, 2'b01, v);
            rd_chk("lane_lo", 2'd1, 16'h001F);
            bus(1'b1, 2'd1, 16'h0000, 2'b10, v);
            rd_chk("lane_hi", 2'd1, 16'h001F);
        end

        // Reset on the ack cycle of a write
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 2'b11; dat_i = 16'h000F;
        adr = 32'hF000_0012; rst = 1'b1;
        @(posedge clk); #1 check("rst_ack_drop", {31'd0, ack}, 32'd0);
        @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        rd_chk("rst_wr_enable", 2'd1, 16'h0000);
        rd_chk("rst_wr_edge",   2'd2, 16'h001F);

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) irq = NI'($urandom);
            cyc   = ($urandom_range(0, 3) != 0);
            stb   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1) == 1;
            adr   = $urandom;
            dat_i = 16'($urandom);
            sel   = 2'($urandom);
            rst   = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
